pixel_compositor: RTL and testbench



---
 rtl/flappy_gfx_pkg.sv | 35 +++
 rtl/pipe_hit_calc.sv | 36 +++
 rtl/pixel_compositor.sv | 157 +++++++++++++++
 tb/tb_pixel_compositor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_gfx_pkg.sv
// Shared geometry widths, default sprite constants and the colour selector for the flappy pixel path.
package flappy_gfx_pkg;

   localparam int H_W   = 10;
   localparam int V_W   = 10;
   localparam int POS_W = 9;
   // Geometry compares are one bit wider than any coordinate so sums never wrap.
   localparam int GEO_W = 11;

   localparam int unsigned DEF_NUM_PIPES = 2;
   localparam int unsigned DEF_COLOR_W   = 1;
   localparam int unsigned DEF_BIRD_X0   = 50;
   localparam int unsigned DEF_BIRD_W    = 50;
   localparam int unsigned DEF_BIRD_H    = 50;
   localparam int unsigned DEF_PIPE_W    = 100;
   localparam int unsigned DEF_GAP_H     = 150;
   localparam int unsigned DEF_GROUND_Y  = 440;

   typedef enum logic [2:0] {
      BLACK,
      SKY,
      PIPE,
      BIRD,
      GROUND
   } color_e;

   function automatic logic [GEO_W-1:0] geo_h(input logic [H_W-1:0] x);
      return GEO_W'(x);
   endfunction

   function automatic logic [GEO_W-1:0] geo_v(input logic [V_W-1:0] y);
      return GEO_W'(y);
   endfunction

endpackage

// File: rtl/pipe_hit_calc.sv
// Combinational hit test of one pixel against one pipe column with a vertical hole.
module pipe_hit_calc
   import flappy_gfx_pkg::*;
#(
   parameter int unsigned PIPE_W = DEF_PIPE_W,
   parameter int unsigned GAP_H  = DEF_GAP_H
) (
   input  logic             en,
   input  logic [H_W-1:0]   h,
   input  logic [V_W-1:0]   v,
   input  logic [H_W-1:0]   pipe_pos,
   input  logic [POS_W-1:0] hole_pos,
   output logic             hit
);

   localparam logic [GEO_W-1:0] PW = GEO_W'(PIPE_W);
   localparam logic [GEO_W-1:0] GH = GEO_W'(GAP_H);

   logic [GEO_W-1:0] h_ext;
   logic [GEO_W-1:0] v_ext;
   logic [GEO_W-1:0] pos_ext;
   logic [GEO_W-1:0] hole_ext;
   logic             in_column;
   logic             outside_hole;

   assign h_ext    = geo_h(h);
   assign v_ext    = geo_v(v);
   assign pos_ext  = geo_h(pipe_pos);
   assign hole_ext = GEO_W'(hole_pos);

   // pipe_pos is the exclusive right edge, so a pipe near h=0 shows only its right part.
   assign in_column    = (h_ext < pos_ext) && ((h_ext + PW) > pos_ext);
   assign outside_hole = (v_ext < hole_ext) || (v_ext > (hole_ext + GH));
   assign hit          = en && in_column && outside_hole;

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage bird/pipe/sky compositor with per-frame sticky collision; fixed 2-cycle latency, never stalls.
// Define PIXEL_COMPOSITOR_GROUND_EN to add the ground band at v_count >= GROUND_Y.
module pixel_compositor
   import flappy_gfx_pkg::*;
#(
   parameter int unsigned NUM_PIPES = DEF_NUM_PIPES,
   parameter int unsigned COLOR_W   = DEF_COLOR_W,
   parameter int unsigned BIRD_X0   = DEF_BIRD_X0,
   parameter int unsigned BIRD_W    = DEF_BIRD_W,
   parameter int unsigned BIRD_H    = DEF_BIRD_H,
   parameter int unsigned PIPE_W    = DEF_PIPE_W,
   parameter int unsigned GAP_H     = DEF_GAP_H,
   parameter int unsigned GROUND_Y  = DEF_GROUND_Y
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       bright,
   input  logic [H_W-1:0]             h_count,
   input  logic [V_W-1:0]             v_count,
   input  logic [POS_W-1:0]           bird_pos,
   input  logic [NUM_PIPES-1:0]       pipe_en,
   input  logic [H_W*NUM_PIPES-1:0]   pipe_pos,
   input  logic [POS_W*NUM_PIPES-1:0] hole_pos,
   output logic [COLOR_W-1:0]         red,
   output logic [COLOR_W-1:0]         green,
   output logic [COLOR_W-1:0]         blue,
   output logic                       collision,
   output logic                       collision_pulse
);

   localparam logic [GEO_W-1:0]   BX_LO = GEO_W'(BIRD_X0);
   localparam logic [GEO_W-1:0]   BX_HI = GEO_W'(BIRD_X0 + BIRD_W);
   localparam logic [GEO_W-1:0]   BH    = GEO_W'(BIRD_H);
   localparam logic [COLOR_W-1:0] MAX   = '1;

   logic [GEO_W-1:0]     h_ext;
   logic [GEO_W-1:0]     v_ext;
   logic [GEO_W-1:0]     bird_ext;
   logic                 bird_hit_c;
   logic [NUM_PIPES-1:0] pipe_hit_c;
   logic                 ground_hit_c;

   logic                 bright_d;
   logic                 frame_start_d;
   logic                 bird_hit_d;
   logic [NUM_PIPES-1:0] pipe_hit_d;
   logic                 ground_hit_d;

   color_e               color_sel;
   logic [COLOR_W-1:0]   red_n;
   logic [COLOR_W-1:0]   green_n;
   logic [COLOR_W-1:0]   blue_n;
   logic                 hit;

   assign h_ext    = geo_h(h_count);
   assign v_ext    = geo_v(v_count);
   assign bird_ext = GEO_W'(bird_pos);

   // bird_pos is the exclusive bottom edge; small values clip the bird at the top rather than wrap.
   assign bird_hit_c = (h_ext > BX_LO) && (h_ext < BX_HI) &&
                       (v_ext < bird_ext) && ((v_ext + BH) > bird_ext);

   for (genvar k = 0; k < NUM_PIPES; k++) begin : g_pipe
      pipe_hit_calc #(
         .PIPE_W (PIPE_W),
         .GAP_H  (GAP_H)
      ) u_pipe_hit (
         .en       (pipe_en[k]),
         .h        (h_count),
         .v        (v_count),
         .pipe_pos (pipe_pos[H_W*k +: H_W]),
         .hole_pos (hole_pos[POS_W*k +: POS_W]),
         .hit      (pipe_hit_c[k])
      );
   end

`ifdef PIXEL_COMPOSITOR_GROUND_EN
   assign ground_hit_c = (v_ext >= GEO_W'(GROUND_Y));
`else
   logic unused_ground_y;
   assign unused_ground_y = |GEO_W'(GROUND_Y);
   assign ground_hit_c    = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         bright_d      <= 1'b0;
         frame_start_d <= 1'b0;
         bird_hit_d    <= 1'b0;
         pipe_hit_d    <= '0;
         ground_hit_d  <= 1'b0;
      end else begin
         bright_d      <= bright;
         frame_start_d <= (h_count == '0) && (v_count == '0);
         bird_hit_d    <= bird_hit_c;
         pipe_hit_d    <= pipe_hit_c;
         ground_hit_d  <= ground_hit_c;
      end
   end

   // Ground sits between the bird and the pipes so pipes visually sink into it.
   always_comb begin
      color_sel = SKY;
      if (!bright_d) begin
         color_sel = BLACK;
      end else if (bird_hit_d) begin
         color_sel = BIRD;
      end else if (ground_hit_d) begin
         color_sel = GROUND;
      end else if (|pipe_hit_d) begin
         color_sel = PIPE;
      end
   end

   always_comb begin
      red_n   = '0;
      green_n = '0;
      blue_n  = '0;
      case (color_sel)
         SKY:    blue_n = MAX;
         PIPE:   green_n = MAX;
         BIRD: begin
            red_n   = MAX;
            green_n = MAX;
         end
         GROUND: begin
            red_n   = MAX;
            green_n = MAX >> 1;
         end
         default: begin
            red_n   = '0;
            green_n = '0;
            blue_n  = '0;
         end
      endcase
   end

   assign hit = bright_d && bird_hit_d && ((|pipe_hit_d) || ground_hit_d);

   // A frame-start pixel clears the flag unless it is itself a hit, which also re-arms the pulse.
   always_ff @(posedge clock) begin
      if (!reset) begin
         red             <= '0;
         green           <= '0;
         blue            <= '0;
         collision       <= 1'b0;
         collision_pulse <= 1'b0;
      end else begin
         red             <= red_n;
         green           <= green_n;
         blue            <= blue_n;
         collision       <= hit || (collision && !frame_start_d);
         collision_pulse <= hit && (!collision || frame_start_d);
      end
   end

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor (default build: 2 pipes, 1-bit colour) with a frame-level reference model.
module tb_pixel_compositor;

   localparam int BX0 = 50;
   localparam int BW  = 50;
   localparam int BH  = 50;
   localparam int PW  = 100;
   localparam int GH  = 150;
   localparam int NP  = 2;

   typedef struct {
      logic [2:0] rgb;
      bit         hit;
      bit         fs;
   } pix_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        bright;
   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic [8:0]  bird_pos;
   logic [1:0]  pipe_en;
   logic [19:0] pipe_pos;
   logic [17:0] hole_pos;
   logic [0:0]  red;
   logic [0:0]  green;
   logic [0:0]  blue;
   logic        collision;
   logic        collision_pulse;

   int checks   = 0;
   int failures = 0;

   logic [2:0] m_rgb   = 3'b000;
   bit         m_coll  = 1'b0;
   bit         m_pulse = 1'b0;
   pix_t       m_prev  = '{rgb: 3'b000, hit: 1'b0, fs: 1'b0};

   pixel_compositor dut (
      .clock           (clock),
      .reset           (reset),
      .bright          (bright),
      .h_count         (h_count),
      .v_count         (v_count),
      .bird_pos        (bird_pos),
      .pipe_en         (pipe_en),
      .pipe_pos        (pipe_pos),
      .hole_pos        (hole_pos),
      .red             (red),
      .green           (green),
      .blue            (blue),
      .collision       (collision),
      .collision_pulse (collision_pulse)
   );

   always #5 clock = ~clock;

   // What a single pixel must look like, straight from the geometry rules.
   function automatic pix_t eval_pixel();
      pix_t p;
      int   h, v, bp, pp, hp;
      bit   bird, anyp;
      h    = int'(h_count);
      v    = int'(v_count);
      bp   = int'(bird_pos);
      bird = (h > BX0) && (h < BX0 + BW) && (v < bp) && (v + BH > bp);
      anyp = 1'b0;
      for (int k = 0; k < NP; k++) begin
         pp = int'(pipe_pos[10*k +: 10]);
         hp = int'(hole_pos[9*k +: 9]);
         if (pipe_en[k] && (h < pp) && (h + PW > pp) && ((v < hp) || (v > hp + GH)))
            anyp = 1'b1;
      end
      if (!bright)   p.rgb = 3'b000;
      else if (bird) p.rgb = 3'b110;
      else if (anyp) p.rgb = 3'b010;
      else           p.rgb = 3'b001;
      p.hit = bright && bird && anyp;
      p.fs  = (h == 0) && (v == 0);
      return p;
   endfunction

   // Output after each edge is the pixel seen at the previous edge; collision is "any hit since frame start".
   always @(posedge clock) begin
      bit old_coll;
      if (!reset) begin
         m_rgb   = 3'b000;
         m_coll  = 1'b0;
         m_pulse = 1'b0;
         m_prev  = '{rgb: 3'b000, hit: 1'b0, fs: 1'b0};
      end else begin
         old_coll = m_coll;
         m_rgb    = m_prev.rgb;
         m_coll   = m_prev.fs ? m_prev.hit : (m_coll || m_prev.hit);
         m_pulse  = m_prev.hit && (!old_coll || m_prev.fs);
         m_prev   = eval_pixel();
      end
   end

   always @(negedge clock) begin
      checks++;
      if ({red, green, blue, collision, collision_pulse} !== {m_rgb, m_coll, m_pulse}) begin
         failures++;
         $display("FAIL model_cmp t=%0t h=%0d v=%0d got rgb/coll/pulse=%b%b%b/%b/%b want %b/%b/%b",
                  $time, h_count, v_count, red, green, blue, collision, collision_pulse,
                  m_rgb, m_coll, m_pulse);
      end
   end

   task automatic drive(input int h, input int v);
      h_count = 10'(h);
      v_count = 10'(v);
      @(posedge clock);
      #1;
   endtask

   task automatic lit(input string name, input logic [4:0] want);
      logic [4:0] got;
      got = {red, green, blue, collision, collision_pulse};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got rgb_coll_pulse=%b want=%b", name, got, want);
      end
   endtask

   initial begin
      reset    = 1'b0;
      bright   = 1'b1;
      h_count  = 10'd300;
      v_count  = 10'd10;
      bird_pos = 9'd200;
      pipe_en  = 2'b00;
      pipe_pos = '0;
      hole_pos = '0;

      // Reset held mid-line, then pipeline refill.
      for (int i = 0; i < 5; i++) begin
         drive(300, 10);
         lit("reset_hold", 5'b000_0_0);
      end
      reset = 1'b1;
      drive(300, 10);
      lit("refill_black", 5'b000_0_0);
      drive(300, 10);
      lit("sky_after_reset", 5'b001_0_0);

      // Bird over pipe 0: one pulse, sticky flag until the next frame start.
      pipe_en         = 2'b01;
      pipe_pos[9:0]   = 10'd110;
      hole_pos[8:0]   = 9'd0;
      drive(0, 0);
      drive(75, 180);
      drive(75, 180);
      lit("bird_hit_first", 5'b110_1_1);
      drive(75, 180);
      lit("pulse_once", 5'b110_1_0);
      drive(300, 10);
      drive(300, 10);
      lit("coll_sticky", 5'b001_1_0);
      drive(0, 0);
      drive(300, 10);
      lit("coll_clear_at_frame", 5'b001_0_0);

      // Two overlapping pipes still give one pulse.
      pipe_en          = 2'b11;
      pipe_pos[19:10]  = 10'd110;
      hole_pos[17:9]   = 9'd0;
      drive(75, 180);
      drive(75, 180);
      lit("dual_pipe_first", 5'b110_1_1);
      drive(75, 180);
      lit("dual_pipe_single_pulse", 5'b110_1_0);

      // Bird clipped at the top, no wrap; bottom edge exclusive.
      pipe_en  = 2'b00;
      bird_pos = 9'd30;
      for (int v = 0; v <= 30; v++) begin
         drive(75, v);
         if (v == 1)  lit("bird_clip_top", 5'b110_1_0);
         if (v == 30) lit("bird_last_row", 5'b110_1_0);
      end
      drive(75, 30);
      lit("bird_bottom_excl", 5'b001_1_0);

      // Pipe partially visible from h=0, then hidden by its enable.
      bird_pos      = 9'd200;
      pipe_en       = 2'b01;
      pipe_pos[9:0] = 10'd60;
      hole_pos[8:0] = 9'd200;
      drive(0, 0);
      drive(300, 10);
      drive(10, 0);
      drive(10, 0);
      lit("pipe_partial", 5'b010_0_0);
      pipe_en = 2'b00;
      drive(10, 0);
      drive(10, 0);
      lit("pipe_disabled", 5'b001_0_0);

      // Blanking while bird and pipe overlap: black and no collision.
      pipe_en       = 2'b01;
      pipe_pos[9:0] = 10'd110;
      hole_pos[8:0] = 9'd0;
      bright        = 1'b0;
      drive(75, 180);
      drive(75, 180);
      lit("blank_black", 5'b000_0_0);
      drive(75, 180);
      lit("blank_no_coll", 5'b000_0_0);
      bright = 1'b1;

      // Horizontal sweep across bird and pipe edges, plus hole boundary rows.
      for (int h = 40; h <= 120; h++) drive(h, 180);
      for (int v = 148; v <= 153; v++) drive(75, v);
      pipe_pos[9:0] = 10'd1000;
      for (int h = 895; h <= 905; h++) drive(h, 400);

      // Reset in the middle of a hit clears everything.
      pipe_pos[9:0] = 10'd110;
      drive(75, 180);
      reset = 1'b0;
      drive(75, 180);
      lit("reset_mid_hit", 5'b000_0_0);
      reset = 1'b1;
      drive(75, 180);
      drive(75, 180);
      drive(75, 180);
      drive(300, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
